// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: memory size and
// the two-bit FSM state encoding.
package instr_fetch_ctrl_pkg;

  localparam int unsigned INSTR_MEM_SIZE = 128;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

endpackage

// File: rtl/instr_fetch_ctrl_buf.sv
// One-entry valid/ready pipeline register holding {instr, pc} for decode.
// Flush wins over load; a drained entry keeps its data bits stable.
module instr_fetch_ctrl_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      instr_reg <= 32'd0;
      pc_reg    <= 32'd0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction memory
// and feeds a one-entry buffer to decode; handles redirects, halt and fault.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned IM_SIZE  = INSTR_MEM_SIZE,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  output logic [31:0] InstrAddr,
  input  logic [31:0] Instr,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        FetchValid,
  output logic [31:0] FetchInstr,
  output logic [31:0] FetchPC,
  input  logic        FetchReady,
  output logic        Halt,
  output logic        Fault
);

  localparam logic [31:0] LAST_PC = 32'(IM_SIZE - 4);

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4;
  logic        redirect_take;
  logic        fetch;
  logic        flush;

  assign pc_plus4      = pc_reg + 32'd4;
  assign redirect_take = Redirect && (state_reg == S_RUN || state_reg == S_HALT);
  assign fetch         = (state_reg == S_RUN) && !redirect_take && (!FetchValid || FetchReady);
  // FAULT holds the buffer empty for as long as it lasts.
  assign flush         = redirect_take || (state_reg == S_FAULT);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect_take) begin
      pc_next = RedirectPC;
      if (RedirectPC[1:0] != 2'b00)
        state_next = S_FAULT;
      else if (RedirectPC > LAST_PC)
        state_next = S_HALT;
      else
        state_next = S_RUN;
    end else begin
      case (state_reg)
        S_IDLE: if (Start) state_next = S_RUN;
        S_RUN: begin
          if (fetch) begin
            pc_next = pc_plus4;
            if (pc_plus4 > LAST_PC) state_next = S_HALT;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  instr_fetch_ctrl_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (fetch),
    .instr_in (Instr),
    .pc_in    (pc_reg),
    .ready    (FetchReady),
    .valid    (FetchValid),
    .instr    (FetchInstr),
    .pc       (FetchPC)
  );

  assign InstrAddr = pc_reg;
  assign Halt      = (state_reg == S_HALT);
  assign Fault     = (state_reg == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; memory word at address A is {16'hC0DE, A[15:0]}.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] InstrAddr;
  logic [31:0] Instr;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'd0;
  logic        FetchValid;
  logic [31:0] FetchInstr;
  logic [31:0] FetchPC;
  logic        FetchReady = 1'b1;
  logic        Halt;
  logic        Fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign Instr = {16'hC0DE, InstrAddr[15:0]};

  instr_fetch_ctrl #(.IM_SIZE(128), .RESET_PC(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .InstrAddr  (InstrAddr),
    .Instr      (Instr),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .FetchValid (FetchValid),
    .FetchInstr (FetchInstr),
    .FetchPC    (FetchPC),
    .FetchReady (FetchReady),
    .Halt       (Halt),
    .Fault      (Fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, FetchValid}, 32'd0);
    chk({tag, "_finstr"}, FetchInstr, 32'd0);
    chk({tag, "_fpc"}, FetchPC, 32'd0);
    chk({tag, "_addr"}, InstrAddr, 32'd0);
    chk({tag, "_halt"}, {31'd0, Halt}, 32'd0);
    chk({tag, "_fault"}, {31'd0, Fault}, 32'd0);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, FetchValid}, 32'd1);
    chk({tag, "_fpc"}, FetchPC, pc);
    chk({tag, "_finstr"}, FetchInstr, {16'hC0DE, pc[15:0]});
    $display("fetch %s pc=%h instr=%h addr=%h", tag, FetchPC, FetchInstr, InstrAddr);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b1;

    // 1: start and stream
    Start = 1'b1;
    step();
    chk("run_first_valid", {31'd0, FetchValid}, 32'd0);
    chk("run_first_addr", InstrAddr, 32'd0);
    step();
    Start = 1'b0;
    chk_fetch("s0", 32'd0);
    chk("s0_addr", InstrAddr, 32'd4);
    step();
    chk_fetch("s4", 32'd4);
    step();
    chk_fetch("s8", 32'd8);

    // 2: stall three cycles at FetchPC=8
    FetchReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("stall", 32'd8);
      chk("stall_addr", InstrAddr, 32'd12);
    end
    FetchReady = 1'b1;
    step();
    chk_fetch("resume12", 32'd12);
    step();
    chk_fetch("resume16", 32'd16);

    // 3: run to end of memory
    for (int pc = 20; pc <= 124; pc += 4) begin
      step();
      chk_fetch("stream", 32'(pc));
    end
    chk("end_halt", {31'd0, Halt}, 32'd1);
    chk("end_addr", InstrAddr, 32'd128);
    step();
    chk("drained_valid", {31'd0, FetchValid}, 32'd0);
    chk("drained_halt", {31'd0, Halt}, 32'd1);
    step();
    chk("halt_idle_valid", {31'd0, FetchValid}, 32'd0);
    chk("halt_idle_addr", InstrAddr, 32'd128);

    // 4: redirect from HALT, then flush a valid buffer
    Redirect = 1'b1;
    RedirectPC = 32'h10;
    step();
    Redirect = 1'b0;
    chk("redir_halt_halt", {31'd0, Halt}, 32'd0);
    chk("redir_halt_addr", InstrAddr, 32'h10);
    chk("redir_halt_valid", {31'd0, FetchValid}, 32'd0);
    step();
    chk_fetch("r10", 32'h10);
    step();
    chk_fetch("r14", 32'h14);
    Redirect = 1'b1;
    RedirectPC = 32'h20;
    step();
    Redirect = 1'b0;
    chk("flush_valid", {31'd0, FetchValid}, 32'd0);
    chk("flush_addr", InstrAddr, 32'h20);
    step();
    chk_fetch("r20", 32'h20);

    // Redirect beyond memory end -> HALT
    Redirect = 1'b1;
    RedirectPC = 32'h80;
    step();
    Redirect = 1'b0;
    chk("redir_oob_halt", {31'd0, Halt}, 32'd1);
    chk("redir_oob_valid", {31'd0, FetchValid}, 32'd0);

    // 5: misaligned redirect -> FAULT, sticky
    Redirect = 1'b1;
    RedirectPC = 32'h22;
    step();
    chk("fault_flag", {31'd0, Fault}, 32'd1);
    chk("fault_valid", {31'd0, FetchValid}, 32'd0);
    chk("fault_addr", InstrAddr, 32'h22);
    RedirectPC = 32'h0;
    Start = 1'b1;
    step();
    step();
    chk("fault_sticky", {31'd0, Fault}, 32'd1);
    chk("fault_sticky_addr", InstrAddr, 32'h22);
    chk("fault_sticky_valid", {31'd0, FetchValid}, 32'd0);
    Redirect = 1'b0;
    Start = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outputs("fault_reset");
    step();
    rst = 1'b1;
    step();
    chk("idle_no_start", {31'd0, FetchValid}, 32'd0);
    chk("idle_addr", InstrAddr, 32'd0);

    // 6: asynchronous reset mid-stream
    Start = 1'b1;
    step();
    step();
    step();
    step();
    chk_fetch("pre_rst8", 32'd8);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    rst = 1'b1;
    Start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
